dds_sweep_ctrl: RTL
===================

DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

Interface
REQ-001 Parameter WIDTH, default 10, DDS phase/RAM address width; frequency word width is WIDTH/2.
REQ-002 Parameter MAX_AMP, default 8, sample and amplitude width.
REQ-003 Parameter DWELL_W, default 16, dwell counter width.
REQ-004 One clock; reset is asynchronous and active-low. Port clk, input, 1, rising-edge clock for all state.
REQ-005 Port res_n, input, 1, asynchronous active-low reset.
REQ-006 Port start, input, 1, single-cycle request to begin a run; sampled only in IDLE.
REQ-007 Port load_en, input, 1, sampled with start; 1 = reload the waveform RAM before the sweep.
REQ-008 Port start_freq / stop_freq / step_freq, input, WIDTH/2 each, sweep bounds and increment; sampled with start.
REQ-009 Port dwell, input, DWELL_W, clocks per step minus one; sampled with start.
REQ-010 Port amp_in, input, MAX_AMP, amplitude for the run; sampled with start.
REQ-011 Port abort, input, 1, synchronous cancel of the current run.
REQ-012 Port smp_valid, input, 1, waveform sample valid.
REQ-013 Port smp_data, input, MAX_AMP, waveform sample.
REQ-014 Port smp_ready, output, 1, sample accepted when smp_valid and smp_ready are both 1.
REQ-015 Port RAM_WR, output, 1, DDS RAM write strobe.
REQ-016 Port RAM_address, output, WIDTH, DDS RAM write address.
REQ-017 Port RAM_input, output, MAX_AMP, DDS RAM write data.
REQ-018 Port freq_cntrl, output, WIDTH/2, DDS frequency word.
REQ-019 Port AMP, output, MAX_AMP, DDS amplitude.
REQ-020 Port busy, output, 1, high in LOAD and SWEEP.
REQ-021 Port done, output, 1, one-cycle pulse at normal sweep completion.

Function
REQ-022 States are IDLE, LOAD, SWEEP, DONE; all outputs are registered except smp_ready = (state==LOAD).
REQ-023 IDLE: start=1 latches all configuration inputs, then goes to LOAD if load_en=1, otherwise to SWEEP; start in any other state is ignored.
REQ-024 LOAD: each accepted sample produces RAM_WR=1, RAM_address=write index, RAM_input=smp_data on the next cycle; the index starts at 0 and increments by 1 per accepted sample.
REQ-025 LOAD: RAM_WR=0 in any cycle after a cycle with no accepted sample; gaps in smp_valid are allowed.
REQ-026 LOAD exits to SWEEP after the 2^WIDTH-th accepted sample (index 2^WIDTH-1); the index does not wrap inside a run.
REQ-027 SWEEP entry: freq_cntrl=start_freq, AMP=amp_in, and the dwell counter is loaded with dwell.
REQ-028 SWEEP: each frequency is held for exactly dwell+1 clocks.
REQ-029 SWEEP: at dwell expiry, the next frequency is freq_cntrl+step_freq, computed at WIDTH/2+1 bits.
REQ-030 SWEEP: if that sum exceeds stop_freq or overflows WIDTH/2 bits, or if step_freq=0, the state goes to DONE and freq_cntrl is not updated.
REQ-031 If stop_freq<start_freq, only start_freq is emitted, for one dwell period.
REQ-032 DONE lasts one cycle: done=1, then the state goes to IDLE; freq_cntrl and AMP are 0 from IDLE entry.
REQ-033 abort=1 in LOAD, SWEEP or DONE forces IDLE next cycle with RAM_WR=0, freq_cntrl=0 and AMP=0, and no done pulse.
REQ-034 abort has priority over start and over a simultaneous sample acceptance; that sample is not written.
REQ-035 In IDLE, RAM_WR=0 and busy=0.

Reset
REQ-036 res_n=0 asynchronously forces: state=IDLE; RAM_WR=0; RAM_address=0; RAM_input=0; freq_cntrl=0; AMP=0; busy=0; done=0; all counters and latched configuration =0.
REQ-037 Reset mid-run discards the run; after res_n rises, a new start is required.

Verification
REQ-038 Load: start with load_en=1, 1024 samples of value i[7:0] with random smp_valid gaps -> exactly 1024 RAM_WR pulses at addresses 0..1023 with matching data, then busy stays 1 and SWEEP begins.
REQ-039 Sweep: load_en=0, start=1, stop=9, step=4, dwell=2, amp=0x80 -> freq_cntrl 1,5,9 for 3 clocks each, AMP=0x80, done pulse once, then freq_cntrl=0.
REQ-040 Edge cases: step=0 -> start_freq for dwell+1 clocks, then done; stop=31, start=30, step=3 -> 30 only, no wrap; stop<start -> single step.
REQ-041 Abort: abort asserted mid-LOAD at index 500 and mid-SWEEP -> IDLE next cycle, no done pulse, no RAM_WR on the abort cycle; start during SWEEP has no effect.
REQ-042 Reset: res_n low mid-SWEEP between clock edges -> outputs 0 immediately; a new run after release behaves as in REQ-039.

Source files
------------

// File: rtl/dds_sweep_ctrl.sv
// DDS sweep controller: optionally streams a waveform into the DDS RAM, then
// steps the frequency word from start to stop, holding each value for dwell+1 clocks.
module dds_sweep_ctrl #(
    parameter int WIDTH   = 10,
    parameter int MAX_AMP = 8,
    parameter int DWELL_W = 16
) (
    input  logic                 clk,
    input  logic                 res_n,
    input  logic                 start,
    input  logic                 load_en,
    input  logic [WIDTH/2-1:0]   start_freq,
    input  logic [WIDTH/2-1:0]   stop_freq,
    input  logic [WIDTH/2-1:0]   step_freq,
    input  logic [DWELL_W-1:0]   dwell,
    input  logic [MAX_AMP-1:0]   amp_in,
    input  logic                 abort,
    input  logic                 smp_valid,
    input  logic [MAX_AMP-1:0]   smp_data,
    output logic                 smp_ready,
    output logic                 RAM_WR,
    output logic [WIDTH-1:0]     RAM_address,
    output logic [MAX_AMP-1:0]   RAM_input,
    output logic [WIDTH/2-1:0]   freq_cntrl,
    output logic [MAX_AMP-1:0]   AMP,
    output logic                 busy,
    output logic                 done
);

    localparam int FW = WIDTH / 2;

    typedef enum logic [1:0] {IDLE, LOAD, SWEEP, DONE} state_t;

    state_t state, state_next;

    logic [FW-1:0]      cfg_start, cfg_stop, cfg_step;
    logic [DWELL_W-1:0] cfg_dwell, dwell_cnt;
    logic [MAX_AMP-1:0] cfg_amp;
    logic [WIDTH-1:0]   wr_idx;
    logic               accept, last_sample, dwell_end, sweep_stop, start_ok;
    logic [FW:0]        freq_sum;

    assign smp_ready   = (state == LOAD);
    assign accept      = smp_valid && smp_ready;
    assign last_sample = (wr_idx == {WIDTH{1'b1}});
    assign dwell_end   = (dwell_cnt == '0);
    assign start_ok    = start && !abort;

    // One extra bit catches a step that would wrap the frequency word.
    assign freq_sum   = {1'b0, freq_cntrl} + {1'b0, cfg_step};
    assign sweep_stop = (cfg_step == '0) || freq_sum[FW] || (freq_sum[FW-1:0] > cfg_stop);

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_next = load_en ? LOAD : SWEEP;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (accept && last_sample) begin
                    state_next = SWEEP;
                end
            end
            SWEEP: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (dwell_end && sweep_stop) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            cfg_start   <= '0;
            cfg_stop    <= '0;
            cfg_step    <= '0;
            cfg_dwell   <= '0;
            cfg_amp     <= '0;
            dwell_cnt   <= '0;
            wr_idx      <= '0;
            RAM_WR      <= 1'b0;
            RAM_address <= '0;
            RAM_input   <= '0;
            freq_cntrl  <= '0;
            AMP         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            RAM_WR <= 1'b0;
            busy   <= (state_next == LOAD) || (state_next == SWEEP);
            done   <= (state_next == DONE);
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        cfg_start <= start_freq;
                        cfg_stop  <= stop_freq;
                        cfg_step  <= step_freq;
                        cfg_dwell <= dwell;
                        cfg_amp   <= amp_in;
                        wr_idx    <= '0;
                        if (!load_en) begin
                            freq_cntrl <= start_freq;
                            AMP        <= amp_in;
                            dwell_cnt  <= dwell;
                        end
                    end
                end
                LOAD: begin
                    // An abort wins over a sample accepted in the same cycle.
                    if (!abort && accept) begin
                        RAM_WR      <= 1'b1;
                        RAM_address <= wr_idx;
                        RAM_input   <= smp_data;
                        wr_idx      <= wr_idx + 1'b1;
                        if (last_sample) begin
                            freq_cntrl <= cfg_start;
                            AMP        <= cfg_amp;
                            dwell_cnt  <= cfg_dwell;
                        end
                    end
                end
                SWEEP: begin
                    if (abort) begin
                        freq_cntrl <= '0;
                        AMP        <= '0;
                    end else if (dwell_end) begin
                        if (!sweep_stop) begin
                            freq_cntrl <= freq_sum[FW-1:0];
                            dwell_cnt  <= cfg_dwell;
                        end
                    end else begin
                        dwell_cnt <= dwell_cnt - 1'b1;
                    end
                end
                DONE: begin
                    freq_cntrl <= '0;
                    AMP        <= '0;
                end
                default: begin
                    freq_cntrl <= '0;
                    AMP        <= '0;
                end
            endcase
        end
    end

endmodule
